// File: rtl/hazard_scoreboard_if.sv
// Consumer-slot bundle for hazard_scoreboard: decoded sources, producer data and resolved operands.
// master drives the consumer side; slave is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2
);
  localparam int SW = $clog2(DEPTH + 1);

  logic                        cons_valid;
  logic [NUM_SRC*REG_AW-1:0]   cons_src_addr;
  logic [NUM_SRC-1:0]          cons_src_used;
  logic [REG_AW-1:0]           cons_rd;
  logic                        cons_regwrite;
  logic                        cons_is_load;
  logic                        flush;
  logic                        freeze;
  logic [NUM_SRC*DATA_W-1:0]   rf_data;
  logic [DEPTH*DATA_W-1:0]     stage_data;
  logic                        issue;
  logic                        stall;
  logic [NUM_SRC*SW-1:0]       fwd_sel;
  logic [NUM_SRC*DATA_W-1:0]   src_data;
  logic [SW-1:0]               occupancy;
  logic [31:0]                 stall_cnt;
  logic [31:0]                 fwd_cnt;

  modport master (
    output cons_valid, cons_src_addr, cons_src_used, cons_rd, cons_regwrite, cons_is_load,
    output flush, freeze, rf_data, stage_data,
    input  issue, stall, fwd_sel, src_data, occupancy, stall_cnt, fwd_cnt
  );

  modport slave (
    input  cons_valid, cons_src_addr, cons_src_used, cons_rd, cons_regwrite, cons_is_load,
    input  flush, freeze, rf_data, stage_data,
    output issue, stall, fwd_sel, src_data, occupancy, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Parametrised forwarding / load-use hazard scoreboard tracking DEPTH in-flight writers.
// Optional perf counters are built only when HAZ_PERF_CNT_EN is defined.
module hazard_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int ALU_STAGE  = 1,
  parameter int LOAD_STAGE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int SW = $clog2(DEPTH + 1);

  logic [DEPTH:1]            v_r;
  logic [DEPTH:1]            ld_r;
  logic [REG_AW-1:0]         rd_r [1:DEPTH];
  logic [DEPTH:1]            ready_s;
  logic [NUM_SRC-1:0]        haz_s;
  logic [NUM_SRC*SW-1:0]     fwd_sel_s;
  logic [NUM_SRC*DATA_W-1:0] src_data_s;
  logic                      stall_s;
  logic                      issue_s;
  logic [SW-1:0]             occ_s;

  // Per-stage readiness: loads become forwardable later than ALU results
  always_comb begin
    ready_s = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      ready_s[k] = ld_r[k] ? (k >= LOAD_STAGE) : (k >= ALU_STAGE);
    end
  end

  // Operand resolution: youngest matching producer wins, stall if it is not ready
  always_comb begin : resolve
    logic [REG_AW-1:0] addr_v;
    logic              use_v;
    logic              found_v;
    logic              hit_v;
    haz_s      = '0;
    fwd_sel_s  = '0;
    src_data_s = '0;
    addr_v     = '0;
    use_v      = 1'b0;
    found_v    = 1'b0;
    hit_v      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      addr_v  = bus.cons_src_addr[i*REG_AW +: REG_AW];
      use_v   = bus.cons_src_used[i] && (addr_v != '0);
      found_v = 1'b0;
      src_data_s[i*DATA_W +: DATA_W] = (addr_v == '0) ? '0 : bus.rf_data[i*DATA_W +: DATA_W];
      for (int k = 1; k <= DEPTH; k++) begin
        hit_v    = use_v && !found_v && v_r[k] && (rd_r[k] == addr_v);
        found_v  = found_v | hit_v;
        haz_s[i] = haz_s[i] | (hit_v & ~ready_s[k]);
        fwd_sel_s[i*SW +: SW] = (hit_v && ready_s[k]) ? SW'(k) : fwd_sel_s[i*SW +: SW];
        src_data_s[i*DATA_W +: DATA_W] = (hit_v && ready_s[k]) ?
            bus.stage_data[(k-1)*DATA_W +: DATA_W] : src_data_s[i*DATA_W +: DATA_W];
      end
    end
  end

  // Issue/stall decision and occupancy popcount
  always_comb begin
    stall_s = bus.cons_valid & (|haz_s) & ~bus.flush & ~bus.freeze;
    issue_s = bus.cons_valid & ~stall_s & ~bus.flush & ~bus.freeze;
    occ_s   = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      occ_s = occ_s + SW'(v_r[k]);
    end
  end

  // Producer pipeline: shifts unless frozen, bubble enters unless the consumer issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r  <= '0;
      ld_r <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        rd_r[k] <= '0;
      end
    end else if (!bus.freeze) begin
      for (int k = 2; k <= DEPTH; k++) begin
        v_r[k]  <= v_r[k-1];
        ld_r[k] <= ld_r[k-1];
        rd_r[k] <= rd_r[k-1];
      end
      v_r[1]  <= issue_s & bus.cons_regwrite & (bus.cons_rd != '0);
      ld_r[1] <= issue_s & bus.cons_is_load;
      rd_r[1] <= bus.cons_rd;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] fwd_cnt_r;

  // Saturating stall / forwarded-issue counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
      fwd_cnt_r   <= 32'd0;
    end else begin
      if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (issue_s && (|fwd_sel_s) && (fwd_cnt_r != 32'hFFFF_FFFF)) begin
        fwd_cnt_r <= fwd_cnt_r + 32'd1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.fwd_cnt   = fwd_cnt_r;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.fwd_cnt   = 32'd0;
`endif

  assign bus.issue     = issue_s;
  assign bus.stall     = stall_s;
  assign bus.fwd_sel   = fwd_sel_s;
  assign bus.src_data  = src_data_s;
  assign bus.occupancy = occ_s;
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed two-stage forwarding and load-use hazard logic of the 5-stage core.
- Tracks in-flight register writers across DEPTH stages downstream of the consumer (operand-read/EX) slot.
- Per source operand, picks the youngest matching producer and muxes its data, or stalls when that producer's result is not yet available.
- Generalises source count, pipeline depth and load latency, and adds freeze and flush handling.

Parameters:
- DATA_W, 32: operand/result width.
- REG_AW, 5: register address width; register 0 is hardwired zero.
- NUM_SRC, 2: number of source operands per instruction.
- DEPTH, 2: number of tracked producer stages (stage 1 = immediately older).
- ALU_STAGE, 1: first stage from which a non-load result is forwardable.
- LOAD_STAGE, 2: first stage from which a load result is forwardable; must satisfy ALU_STAGE <= LOAD_STAGE <= DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cons_valid  in  1  valid instruction in consumer slot.
- cons_src_addr  in  NUM_SRC*REG_AW  source register addresses, src i at [i*REG_AW +: REG_AW].
- cons_src_used  in  NUM_SRC  source i is actually read.
- cons_rd  in  REG_AW  destination register.
- cons_regwrite  in  1  consumer writes cons_rd.
- cons_is_load  in  1  consumer is a load.
- flush  in  1  kill the consumer this cycle.
- freeze  in  1  global hold; no stage advances.
- rf_data  in  NUM_SRC*DATA_W  register-file read data per source.
- stage_data  in  DEPTH*DATA_W  result currently held in stage k at [(k-1)*DATA_W +: DATA_W].
- issue  out  1  consumer advances into stage 1 at this edge.
- stall  out  1  hazard stall (excludes freeze and flush).
- fwd_sel  out  NUM_SRC*SW  SW=$clog2(DEPTH+1); 0 selects rf_data, k selects stage k.
- src_data  out  NUM_SRC*DATA_W  resolved operand data.
- occupancy  out  SW  number of valid stage entries.
- stall_cnt  out  32  perf counter, see optional feature.
- fwd_cnt  out  32  perf counter, see optional feature.

Behaviour:
- Per stage k, registered entry holds {v, rd, is_load}. An entry is created only when cons_regwrite=1 and cons_rd!=0; otherwise a bubble (v=0) is inserted.
- Entry is "ready" when k >= (is_load ? LOAD_STAGE : ALU_STAGE).
- Per source i with cons_src_used[i]=1 and addr!=0: match = v && rd==addr; the youngest (lowest k) match wins.
  - Winner ready: fwd_sel=k, src_data=stage_data[k].
  - Winner not ready: hazard.
  - No match: fwd_sel=0, src_data=rf_data.
- Unused sources and addr==0 give fwd_sel=0; src_data is rf_data, or 0 for addr==0.
- stall = cons_valid & any hazard & ~flush & ~freeze.
- issue = cons_valid & ~stall & ~flush & ~freeze.
- All of the above is combinational from current entries and inputs; there are no extra cycles of latency.
- Each clock edge:
  - freeze=1: all entries hold.
  - Otherwise: entry k <- entry k-1 for k>=2; entry 1 <- consumer entry if issue, else a bubble (covers stall, flush, cons_valid=0). Entry DEPTH falls off, since the register file has written it by then.
- Priority: freeze > flush > stall.
- A stall never loses an older producer: producers keep draining, so a load reaches LOAD_STAGE after at most LOAD_STAGE-1 stall cycles.
- occupancy is the popcount of entry v bits.
- Reset (async, rst_n=0): all v=0 and counters=0. Outputs settle to stall=0, occupancy=0, fwd_sel=0, issue=cons_valid&~flush&~freeze.
- Reset asserted mid-stall clears all entries immediately; the first cycle after reset has no hazards.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - stall_cnt increments on each cycle with stall=1.
  - fwd_cnt increments on each cycle with issue=1 and any fwd_sel!=0.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- HAZ_PERF_CNT_EN undefined: no counter flops are built; stall_cnt and fwd_cnt are tied to 0.

Test Plan:
- ALU->ALU back-to-back: issue rd=3 (ALU), next cycle consumer src0=3 with stage_data[1]=0xA5A5 -> stall=0, fwd_sel0=1, src_data0=0xA5A5.
- Load-use with defaults: issue load rd=4, next consumer src1=4 -> stall=1 for exactly 1 cycle. Then fwd_sel1=2, src_data1=stage_data[2], issue=1, and stage 1 held a bubble during the stall.
- Youngest wins: stage1 rd=5 (ALU), stage2 rd=5 (ALU), consumer src0=5 -> fwd_sel0=1. With src_addr=0 and stage rd=0 never created -> fwd_sel=0, src_data=0.
- Freeze during stall: load in stage 1, freeze=1 for 3 cycles -> occupancy constant, stall=0, issue=0. After release, 1 stall cycle, then forward from stage 2.
- Flush and reset: flush=1 with matching hazard -> stall=0, issue=0, bubble enters stage 1. rst_n=0 mid-stall -> occupancy=0 asynchronously, stall=0.
- With HAZ_PERF_CNT_EN: run the load-use test 10 times -> stall_cnt=10, fwd_cnt=10. Without the macro, both stay 0.
